// File: rtl/reg_wb_ctrl.sv
// Writeback controller: merges the ALU result channel and buffered load returns into one registered
// register-file write port. Optional starvation guard for loads is enabled by WB_STARVE_GUARD_EN.
module reg_wb_ctrl #(
    parameter int NUM_REG        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH      = 32,
    parameter int LD_FIFO_DEPTH  = 4,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]       alu_rd,
    input  logic [REG_WIDTH-1:0]            alu_data,
    input  logic                            ld_valid,
    output logic                            ld_ready,
    input  logic [REG_ADDR_WIDTH-1:0]       ld_rd,
    input  logic [REG_WIDTH-1:0]            ld_data,
    output logic                            wr_en,
    output logic [REG_ADDR_WIDTH-1:0]       addr_rd,
    output logic [REG_WIDTH-1:0]            data_rd,
    output logic [NUM_REG-1:0]              rd_busy,
    output logic [$clog2(LD_FIFO_DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(LD_FIFO_DEPTH);
    localparam int CW = PW + 1;

    if (NUM_REG != 2 ** REG_ADDR_WIDTH) begin : g_bad_num_reg
        $error("reg_wb_ctrl: NUM_REG must equal 2**REG_ADDR_WIDTH");
    end
    if (LD_FIFO_DEPTH < 2 || (LD_FIFO_DEPTH & (LD_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("reg_wb_ctrl: LD_FIFO_DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("reg_wb_ctrl: STARVE_LIMIT must be >= 1");
    end

    // Both channels transfer on a cycle where valid && ready; ready never looks at valid.
    logic [CW-1:0]             count_q, count_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_q   [LD_FIFO_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] mem_rd_d   [LD_FIFO_DEPTH];
    logic [REG_WIDTH-1:0]      mem_data_q [LD_FIFO_DEPTH];
    logic [REG_WIDTH-1:0]      mem_data_d [LD_FIFO_DEPTH];
    logic                      wr_en_q, wr_en_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]      data_q, data_d;

    logic                      alu_fire;
    logic                      ld_fire;
    logic                      push;
    logic                      pop;
    logic                      fifo_empty;
    logic [REG_ADDR_WIDTH-1:0] head_rd;
    logic [REG_WIDTH-1:0]      head_data;
    logic [NUM_REG-1:0]        busy_c;
    logic [PW-1:0]             off;

    assign fifo_empty = (count_q == '0);
    assign ld_ready   = (count_q < CW'(LD_FIFO_DEPTH));
    assign alu_fire   = alu_valid && alu_ready;
    assign ld_fire    = ld_valid && ld_ready;
    // Loads aimed at r0 complete their handshake but never occupy a slot.
    assign push       = ld_fire && (ld_rd != '0);
    assign pop        = !alu_fire && !fifo_empty;
    assign head_rd    = mem_rd_q[rd_ptr_q];
    assign head_data  = mem_data_q[rd_ptr_q];

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign alu_ready = (starve_q != SW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_fire) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign alu_ready = 1'b1;
`endif

    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        // The ALU owns the write slot whenever it transfers, even for r0.
        if (alu_fire) begin
            if (alu_rd != '0) begin
                wr_en_d = 1'b1;
                addr_d  = alu_rd;
                data_d  = alu_data;
            end
        end else if (pop) begin
            if (head_rd != '0) begin
                wr_en_d = 1'b1;
                addr_d  = head_rd;
                data_d  = head_data;
            end
        end

        if (push) begin
            mem_rd_d[wr_ptr_q]   = ld_rd;
            mem_data_d[wr_ptr_q] = ld_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        busy_c = '0;
        off    = '0;
        for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                busy_c[mem_rd_q[i]] = 1'b1;
            end
        end
        busy_c[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign addr_rd    = addr_q;
    assign data_rd    = data_q;
    assign rd_busy    = busy_c;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: directed scenarios plus random traffic against a queue-based write-stream model.
// Build with WB_STARVE_GUARD_EN defined to exercise the load starvation guard.
module tb_reg_wb_ctrl;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        wr_en;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic [31:0] rd_busy;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;

    // Model: pending loads as {rd, data}, plus the visible write-port registers.
    logic [36:0] exp_q[$];
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_starve;
    bit          exp_alu_ready, exp_ld_ready, obs_alu_ready, obs_ld_ready;
    bit          alu_acc, ld_acc;

    reg_wb_ctrl #(
        .NUM_REG(32), .REG_ADDR_WIDTH(5), .REG_WIDTH(32),
        .LD_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .wr_en(wr_en), .addr_rd(addr_rd), .data_rd(data_rd),
        .rd_busy(rd_busy), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (exp_q[i]) b[exp_q[i][36:32]] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_wr     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_starve = 0;
    endtask

    // One clock: drive at the falling edge, predict the edge, sample at the next falling edge.
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ldat);
        int          had;
        bit          do_pop;
        logic [36:0] e;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldat;
        #1;
        obs_alu_ready = alu_ready;
        obs_ld_ready  = ld_ready;
        exp_ld_ready  = (exp_q.size() < DEPTH);
`ifdef WB_STARVE_GUARD_EN
        exp_alu_ready = (m_starve != LIMIT);
`else
        exp_alu_ready = 1'b1;
`endif
        alu_acc = av && exp_alu_ready;
        ld_acc  = lv && exp_ld_ready;
        had     = exp_q.size();
        do_pop  = !alu_acc && had > 0;
        m_wr    = 1'b0;
        if (alu_acc) begin
            if (ard != 0) begin
                m_wr = 1'b1; m_addr = ard; m_data = adat;
            end
        end else if (do_pop) begin
            e = exp_q.pop_front();
            m_wr = 1'b1; m_addr = e[36:32]; m_data = e[31:0];
        end
        if (ld_acc && lrd != 0) exp_q.push_back({lrd, ldat});
        if (do_pop || had == 0) m_starve = 0;
        else if (alu_acc) m_starve = m_starve + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_vec++; if (addr_rd !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", addr_rd); end
        n_vec++; if (data_rd !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_rd); end
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_vec++; if (rd_busy !== 32'd0) begin n_err++; $display("FAIL reset_busy: got %h want 0", rd_busy); end
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_alu_ready: got %b want 1", alu_ready); end

        // Hold the ALU busy so two loads stay buffered, then reset mid-cycle.
        step(1'b1, 5'd9, 32'h1111_0009, 1'b1, 5'd3, 32'h3333_3333);
        step(1'b1, 5'd9, 32'h1111_0009, 1'b1, 5'd4, 32'h4444_4444);
        n_vec++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL midrun_count: got %0d want 2", fifo_count); end
        n_vec++; if (rd_busy !== 32'h0000_0018) begin n_err++; $display("FAIL midrun_busy: got %h want 00000018", rd_busy); end
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL midrun_wr_en: got %b want 1", wr_en); end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL async_wr_en: got %b want 0", wr_en); end
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", fifo_count); end
        n_vec++; if (rd_busy !== 32'd0) begin n_err++; $display("FAIL async_busy: got %h want 0", rd_busy); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL release_ld_ready: got %b want 1", ld_ready); end
        n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL release_alu_ready: got %b want 1", alu_ready); end
    endtask

    task automatic test_alu_single();
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL alu_wr_en: got %b want 1", wr_en); end
        n_vec++; if (addr_rd !== 5'd5) begin n_err++; $display("FAIL alu_addr: got %0d want 5", addr_rd); end
        n_vec++; if (data_rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alu_data: got %h want deadbeef", data_rd); end
        idle();
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL alu_one_cycle: got %b want 0", wr_en); end
        n_vec++; if (addr_rd !== 5'd5) begin n_err++; $display("FAIL alu_addr_hold: got %0d want 5", addr_rd); end
    endtask

    task automatic test_load_single();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234_5678);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL ld_early_wr: got %b want 0", wr_en); end
        n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL ld_count: got %0d want 1", fifo_count); end
        n_vec++; if (rd_busy !== 32'h0000_0080) begin n_err++; $display("FAIL ld_busy: got %h want 00000080", rd_busy); end
        idle();
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL ld_wr_en: got %b want 1", wr_en); end
        n_vec++; if (addr_rd !== 5'd7) begin n_err++; $display("FAIL ld_addr: got %0d want 7", addr_rd); end
        n_vec++; if (data_rd !== 32'h1234_5678) begin n_err++; $display("FAIL ld_data: got %h want 12345678", data_rd); end
        n_vec++; if (rd_busy !== 32'd0) begin n_err++; $display("FAIL ld_busy_clear: got %h want 0", rd_busy); end
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL ld_count_clear: got %0d want 0", fifo_count); end
        idle();
    endtask

    task automatic test_starve();
        int         idx;
        bit         saw_full, saw_alu_low;
        logic [4:0] got[$];
        idx = 0;
        saw_full = 0;
        saw_alu_low = 0;
        for (int c = 0; c < 20; c++) begin
            step(c < 12, 5'd9, 32'hA0A0_0009, idx < 4, 5'(idx + 1), 32'hB000_0000 + 32'(idx));
            if (ld_acc) idx++;
            if (!obs_ld_ready) saw_full = 1;
            if (!obs_alu_ready) saw_alu_low = 1;
            n_vec++; if (obs_alu_ready !== exp_alu_ready) begin n_err++; $display("FAIL starve_alu_ready c%0d: got %b want %b", c, obs_alu_ready, exp_alu_ready); end
            n_vec++; if (obs_ld_ready !== exp_ld_ready) begin n_err++; $display("FAIL starve_ld_ready c%0d: got %b want %b", c, obs_ld_ready, exp_ld_ready); end
            n_vec++; if (fifo_count !== 3'(exp_q.size())) begin n_err++; $display("FAIL starve_count c%0d: got %0d want %0d", c, fifo_count, exp_q.size()); end
            n_vec++; if (wr_en !== m_wr) begin n_err++; $display("FAIL starve_wr_en c%0d: got %b want %b", c, wr_en, m_wr); end
            n_vec++; if (addr_rd !== m_addr) begin n_err++; $display("FAIL starve_addr c%0d: got %0d want %0d", c, addr_rd, m_addr); end
            if (wr_en === 1'b1 && addr_rd !== 5'd9) got.push_back(addr_rd);
        end
        n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL starve_drain_size: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_vec++; if (got[i] !== 5'(i + 1)) begin n_err++; $display("FAIL starve_order[%0d]: got %0d want %0d", i, got[i], i + 1); end
        end
`ifdef WB_STARVE_GUARD_EN
        n_vec++; if (saw_alu_low !== 1'b1) begin n_err++; $display("FAIL guard_alu_low: got %b want 1", saw_alu_low); end
`else
        n_vec++; if (saw_full !== 1'b1) begin n_err++; $display("FAIL starve_full: got %b want 1", saw_full); end
        n_vec++; if (saw_alu_low !== 1'b0) begin n_err++; $display("FAIL alu_ready_tied: got %b want 0", saw_alu_low); end
`endif
    endtask

    task automatic test_zero_rd();
        step(1'b1, 5'd0, 32'hCAFE_F00D, 1'b1, 5'd0, 32'hFACE_B00C);
        n_vec++; if (obs_alu_ready !== 1'b1) begin n_err++; $display("FAIL zero_alu_hs: got %b want 1", obs_alu_ready); end
        n_vec++; if (obs_ld_ready !== 1'b1) begin n_err++; $display("FAIL zero_ld_hs: got %b want 1", obs_ld_ready); end
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL zero_wr_en: got %b want 0", wr_en); end
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL zero_count: got %0d want 0", fifo_count); end
        idle();
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL zero_no_pop: got %b want 0", wr_en); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 5'd9, 32'h0000_0009, 1'b1, 5'd10, 32'hAAAA_0010);
        step(1'b1, 5'd9, 32'h0000_0009, 1'b1, 5'd11, 32'hAAAA_0011);
        n_vec++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL b2b_pre_count: got %0d want 2", fifo_count); end
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hAAAA_0012);
        n_vec++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", fifo_count); end
        n_vec++; if (addr_rd !== 5'd10 || wr_en !== 1'b1) begin n_err++; $display("FAIL b2b_oldest: got %0d/%b want 10/1", addr_rd, wr_en); end
        n_vec++; if (data_rd !== 32'hAAAA_0010) begin n_err++; $display("FAIL b2b_data: got %h want aaaa0010", data_rd); end
        n_vec++; if (rd_busy !== 32'h0000_1800) begin n_err++; $display("FAIL b2b_busy: got %h want 00001800", rd_busy); end
        idle();
        n_vec++; if (addr_rd !== 5'd11) begin n_err++; $display("FAIL b2b_second: got %0d want 11", addr_rd); end
        idle();
        n_vec++; if (addr_rd !== 5'd12) begin n_err++; $display("FAIL b2b_third: got %0d want 12", addr_rd); end
        idle();
    endtask

    task automatic test_random();
        bit          p_valid;
        logic [4:0]  p_rd;
        logic [31:0] p_data;
        int          pct;
        p_valid = 0;
        p_rd    = '0;
        p_data  = '0;
        for (int c = 0; c < 400; c++) begin
            pct = ((c / 50) % 2 == 0) ? 85 : 30;
            if (!p_valid && $urandom_range(99, 0) < pct) begin
                p_valid = 1;
                p_rd    = 5'($urandom_range(31, 0));
                p_data  = $urandom;
            end
            step(p_valid, p_rd, p_data, $urandom_range(1, 0) == 1, 5'($urandom_range(31, 0)), $urandom);
            if (alu_acc) p_valid = 0;
            n_vec++; if (obs_alu_ready !== exp_alu_ready) begin n_err++; $display("FAIL rnd_alu_ready c%0d: got %b want %b", c, obs_alu_ready, exp_alu_ready); end
            n_vec++; if (obs_ld_ready !== exp_ld_ready) begin n_err++; $display("FAIL rnd_ld_ready c%0d: got %b want %b", c, obs_ld_ready, exp_ld_ready); end
            n_vec++; if (wr_en !== m_wr) begin n_err++; $display("FAIL rnd_wr_en c%0d: got %b want %b", c, wr_en, m_wr); end
            n_vec++; if (addr_rd !== m_addr) begin n_err++; $display("FAIL rnd_addr c%0d: got %0d want %0d", c, addr_rd, m_addr); end
            n_vec++; if (data_rd !== m_data) begin n_err++; $display("FAIL rnd_data c%0d: got %h want %h", c, data_rd, m_data); end
            n_vec++; if (fifo_count !== 3'(exp_q.size())) begin n_err++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, fifo_count, exp_q.size()); end
            n_vec++; if (rd_busy !== model_busy()) begin n_err++; $display("FAIL rnd_busy c%0d: got %h want %h", c, rd_busy, model_busy()); end
        end
        for (int c = 0; c < 8; c++) idle();
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rnd_drain: got %0d want 0", fifo_count); end
    endtask

    initial begin
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        ld_valid  = 1'b0;
        ld_rd     = '0;
        ld_data   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        test_reset();
        test_alu_single();
        test_load_single();
        test_starve();
        test_zero_rd();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
Writeback controller that drives the register file's single write port (wr_en / addr_rd / data_rd). It merges two result producers into one registered write stream: the single-cycle ALU result channel and the multi-cycle load-return channel from DMEM. Load returns are buffered in a small FIFO. A per-register busy mask lets decode stall on pending load destinations.

Parameters:
NUM_REG, 32, number of architectural registers.
REG_ADDR_WIDTH, 5, register index width; NUM_REG = 2**REG_ADDR_WIDTH.
REG_WIDTH, 32, register data width.
LD_FIFO_DEPTH, 4, load-return buffer entries; power of two, >= 2.
STARVE_LIMIT, 3, consecutive ALU-won cycles with loads pending before a load is forced (used only with the optional feature); >= 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
alu_valid  in  1  ALU result present this cycle.
alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
alu_rd  in  REG_ADDR_WIDTH  ALU destination register.
alu_data  in  REG_WIDTH  ALU result.
ld_valid  in  1  load-return data present.
ld_ready  out  1  load return accepted when ld_valid && ld_ready.
ld_rd  in  REG_ADDR_WIDTH  load destination register.
ld_data  in  REG_WIDTH  load data.
wr_en  out  1  register file write enable, registered.
addr_rd  out  REG_ADDR_WIDTH  register file write address, registered.
data_rd  out  REG_WIDTH  register file write data, registered.
rd_busy  out  NUM_REG  bit i = 1 while any FIFO entry targets register i.
fifo_count  out  log2(LD_FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous, with immediate effect mid-operation: wr_en = 0, addr_rd = 0, data_rd = 0, FIFO empty, fifo_count = 0, rd_busy = 0, starvation counter = 0. On release, ld_ready = 1 and alu_ready = 1.
- ld_ready = (fifo_count < LD_FIFO_DEPTH). It depends only on registered count; a pop in the same cycle does not raise it.
- Accepted load with ld_rd = 0: the handshake completes, but the load is discarded and not pushed.
- Accepted load with ld_rd != 0: pushed at the clock edge; FIFO order is preserved.
- Each cycle, exactly one write source is selected for the next edge:
  - (a) If alu_valid && alu_ready: the ALU result is selected.
  - (b) Otherwise, if the FIFO is non-empty: the FIFO head is popped.
  - (c) Otherwise: no write.
- Output register update at the edge:
  - Selected source with rd != 0: wr_en <= 1, and addr_rd/data_rd load the selected rd/data.
  - Otherwise: wr_en <= 0, and addr_rd/data_rd hold their previous values.
  - An ALU result with alu_rd = 0 still consumes the slot, so no FIFO pop occurs that cycle.
- Latency:
  - ALU: wr_en is high in the cycle after acceptance.
  - Load into an empty FIFO with no ALU activity: pushed at edge N, popped at edge N+1, wr_en high during cycle N+1..N+2, i.e. 2 cycles after acceptance.
- Simultaneous push and pop: fifo_count is unchanged. Full FIFO plus pop: ld_ready stays 0 that cycle and becomes 1 in the next.
- rd_busy is combinational from the valid FIFO entries.
  - A register's bit clears in the cycle after its last entry pops.
  - The bit for register 0 is always 0.
- Ordering between the ALU and loads to the same rd is upstream's responsibility, using rd_busy. This block does not reorder or check it.
- alu_ready = 1 always unless the optional feature is enabled.
- Pointers wrap modulo LD_FIFO_DEPTH. fifo_count never exceeds LD_FIFO_DEPTH and never underflows.

Optional Feature:
Macro: WB_STARVE_GUARD_EN.
- With WB_STARVE_GUARD_EN defined, a starvation counter counts cycles where the FIFO is non-empty and an ALU result is accepted.
  - The counter clears on any FIFO pop and whenever the FIFO is empty.
  - When the counter equals STARVE_LIMIT, alu_ready = 0 for that cycle. alu_ready is derived from registered state only.
  - In that cycle the FIFO head is popped and written, and the counter clears.
  - The ALU producer must hold alu_valid, alu_rd and alu_data until accepted.
- Without WB_STARVE_GUARD_EN: no counter, and alu_ready is tied to 1. Loads may starve while the ALU is continuously valid.

Test Plan:
1. Assert reset mid-run with 2 FIFO entries -> wr_en = 0, fifo_count = 0, rd_busy = 0 immediately; ld_ready = 1 after release.
2. alu_valid = 1, alu_rd = 5, alu_data = 0xDEADBEEF for one cycle -> the next cycle shows wr_en = 1, addr_rd = 5, data_rd = 0xDEADBEEF for exactly one cycle.
3. Load with ld_rd = 7, ld_data = 0x12345678 and idle ALU -> rd_busy[7] = 1 and fifo_count = 1 for one cycle, then wr_en = 1, addr_rd = 7, data_rd = 0x12345678 two cycles after acceptance.
4. Drive 4 loads to rd = 1..4 while alu_valid is held (rd = 9) -> fifo_count reaches 4 and ld_ready = 0. Without the guard, the loads drain in order 1, 2, 3, 4 only after alu_valid drops. With WB_STARVE_GUARD_EN, alu_ready = 0 on every 4th cycle and rd 1..4 are written interleaved.
5. alu_rd = 0 and ld_rd = 0 with nonzero data -> both handshakes complete, wr_en stays 0, and fifo_count stays 0.
6. Push and pop in the same cycle with fifo_count = 2 -> fifo_count stays 2 and the oldest entry is written first.
